// File: rtl/trng_pkg.sv
// Shared register map, STATUS layout and identity words for the TRNG debug controller.
// Used by trng_debug_ctrl_mc and its optional debug FIFO (TRNG_DEBUG_FIFO_EN).
package trng_pkg;

  localparam logic [7:0] ADDR_NAME0   = 8'h00;
  localparam logic [7:0] ADDR_NAME1   = 8'h01;
  localparam logic [7:0] ADDR_VERSION = 8'h02;
  localparam logic [7:0] ADDR_CTRL    = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h09;
  localparam logic [7:0] ADDR_ROUNDS  = 8'h0a;
  localparam logic [7:0] ADDR_SRC_EN  = 8'h0b;
  localparam logic [7:0] ADDR_SRC_SEL = 8'h0c;
  localparam logic [7:0] ADDR_LEVEL   = 8'h0d;
  localparam logic [7:0] ADDR_DATA    = 8'h10;

  localparam logic [31:0] CORE_NAME0   = 32'h74726e67;
  localparam logic [31:0] CORE_NAME1   = 32'h2d646267;
  localparam logic [31:0] CORE_VERSION = 32'h302e3130;

  localparam int STAT_CSPRNG_ERR = 0;
  localparam int STAT_EMPTY      = 1;
  localparam int STAT_FULL       = 2;
  localparam int STAT_OVERFLOW   = 3;

  typedef struct packed {
    logic ovf;
    logic full;
    logic empty;
    logic err;
  } status_t;

  function automatic logic is_writable(input logic [7:0] a);
    return (a == ADDR_CTRL) || (a == ADDR_STATUS) ||
           (a == ADDR_ROUNDS) || (a == ADDR_SRC_EN) ||
           (a == ADDR_SRC_SEL);
  endfunction

endpackage

// File: rtl/trng_debug_fifo.sv
// Debug sample FIFO: 32-bit words, power-of-two DEPTH, level 0..DEPTH.
// Built only when TRNG_DEBUG_FIFO_EN is defined.
module trng_debug_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/trng_debug_ctrl_mc.sv
// TRNG debug controller: register API, CSPRNG control, sticky alarms.
// Define TRNG_DEBUG_FIFO_EN to build the debug sample FIFO.
module trng_debug_ctrl_mc
  import trng_pkg::*;
#(
  parameter int         NUM_SRC        = 4,
  parameter int         FIFO_DEPTH     = 16,
  parameter logic [4:0] DEFAULT_ROUNDS = 5'd24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cs,
  input  logic                  we,
  input  logic [7:0]            address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  error,
  input  logic [32*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]    src_valid,
  output logic [NUM_SRC-1:0]    src_enable,
  output logic                  csprng_debug_mode,
  output logic [4:0]            csprng_num_rounds,
  output logic                  csprng_reseed,
  input  logic                  csprng_error,
  output logic                  security_error
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          rd;
  logic          wr;
  logic          wr_en;
  logic [2:0]    sel;
  logic          sel_bad;
  logic          sel_wr_bad;
  logic          mapped;
  logic          rd_err;
  logic          wr_err;
  logic [31:0]   rdata;
  logic          err_q;
  logic          ovf_q;
  logic          ovf_set;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic [31:0]   fifo_head;
  logic          pop;
  logic          flush;
  status_t       status;
  logic          unused_ok;

  assign rd         = cs & ~we;
  assign wr         = cs & we;
  assign sel_bad    = 32'(sel) >= NUM_SRC;
  assign sel_wr_bad = 32'(write_data[2:0]) >= NUM_SRC;
  assign unused_ok  = ^{write_data, src_data, src_valid};

  assign status = '{ovf: ovf_q, full: fifo_full,
                    empty: fifo_empty, err: err_q};

  always_comb begin
    rdata  = '0;
    mapped = 1'b1;
    case (address)
      ADDR_NAME0:   rdata = CORE_NAME0;
      ADDR_NAME1:   rdata = CORE_NAME1;
      ADDR_VERSION: rdata = CORE_VERSION;
      ADDR_CTRL:    rdata = {31'b0, csprng_debug_mode};
      ADDR_STATUS:  rdata = 32'(status);
      ADDR_ROUNDS:  rdata = {27'b0, csprng_num_rounds};
      ADDR_SRC_EN:  rdata = 32'(src_enable);
      ADDR_SRC_SEL: rdata = {29'b0, sel};
`ifdef TRNG_DEBUG_FIFO_EN
      ADDR_LEVEL:   rdata = 32'(fifo_level);
      ADDR_DATA:    rdata = fifo_empty ? '0 : fifo_head;
`endif
      default:      mapped = 1'b0;
    endcase
  end

  assign rd_err = rd & (~mapped | ((address == ADDR_SRC_SEL) & sel_bad));
  assign wr_err = wr & (~is_writable(address) |
                  ((address == ADDR_SRC_SEL) & sel_wr_bad));
  assign error     = rd_err | wr_err;
  assign read_data = error ? '0 : rdata;
  assign wr_en     = wr & ~wr_err;

  assign flush = wr_en & (address == ADDR_CTRL) & ~write_data[0];
  assign pop   = rd & (address == ADDR_DATA) & ~fifo_empty;

`ifdef TRNG_DEBUG_FIFO_EN
  logic        push;
  logic [31:0] push_data;

  always_comb begin
    push_data = '0;
    push      = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel == i[2:0]) begin
        push_data = src_data[32*i +: 32];
        push      = csprng_debug_mode & src_valid[i] & src_enable[i];
      end
    end
  end

  assign ovf_set = push & fifo_full & ~pop & ~flush;

  trng_debug_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wdata   (push_data),
    .rdata   (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );
`else
  assign ovf_set    = 1'b0;
  assign fifo_full  = 1'b0;
  assign fifo_empty = 1'b0;
  assign fifo_level = '0;
  assign fifo_head  = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csprng_debug_mode <= 1'b0;
      csprng_reseed     <= 1'b0;
      csprng_num_rounds <= DEFAULT_ROUNDS;
      src_enable        <= '1;
      sel               <= '0;
      err_q             <= 1'b0;
      ovf_q             <= 1'b0;
    end else begin
      csprng_reseed <= wr_en & (address == ADDR_CTRL) & write_data[1];
      if (wr_en) begin
        case (address)
          ADDR_CTRL:    csprng_debug_mode <= write_data[0];
          ADDR_ROUNDS:  csprng_num_rounds <= write_data[4:0];
          ADDR_SRC_EN:  src_enable        <= write_data[NUM_SRC-1:0];
          ADDR_SRC_SEL: sel               <= write_data[2:0];
          default:      ;
        endcase
      end
      // A new event always beats a W1C on the same edge.
      err_q <= csprng_error | (err_q & ~(wr_en &
               (address == ADDR_STATUS) & write_data[STAT_CSPRNG_ERR]));
      ovf_q <= ovf_set | (ovf_q & ~(wr_en &
               (address == ADDR_STATUS) & write_data[STAT_OVERFLOW]));
    end
  end

  assign security_error = err_q | ovf_q;

endmodule

// File: tb/tb_trng_debug_ctrl_mc.sv
// Directed bench for trng_debug_ctrl_mc, FIFO checks follow TRNG_DEBUG_FIFO_EN.
// Expected values are hand-computed constants.
module tb_trng_debug_ctrl_mc;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cs;
  logic         we;
  logic [7:0]   address;
  logic [31:0]  write_data;
  logic [31:0]  read_data;
  logic         error;
  logic [127:0] src_data;
  logic [3:0]   src_valid;
  logic [3:0]   src_enable;
  logic         csprng_debug_mode;
  logic [4:0]   csprng_num_rounds;
  logic         csprng_reseed;
  logic         csprng_error;
  logic         security_error;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef TRNG_DEBUG_FIFO_EN
  localparam logic [31:0] ST_IDLE = 32'h2;
`else
  localparam logic [31:0] ST_IDLE = 32'h0;
`endif

  trng_debug_ctrl_mc #(
    .NUM_SRC        (4),
    .FIFO_DEPTH     (16),
    .DEFAULT_ROUNDS (5'd24)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .cs                (cs),
    .we                (we),
    .address           (address),
    .write_data        (write_data),
    .read_data         (read_data),
    .error             (error),
    .src_data          (src_data),
    .src_valid         (src_valid),
    .src_enable        (src_enable),
    .csprng_debug_mode (csprng_debug_mode),
    .csprng_num_rounds (csprng_num_rounds),
    .csprng_reseed     (csprng_reseed),
    .csprng_error      (csprng_error),
    .security_error    (security_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h want %h", tag, got, exp);
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d,
                        output logic e);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; address = a;
    #1;
    d = read_data;
    e = error;
    @(posedge clk);
    #1;
    cs = 1'b0;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d,
                        output logic e);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; address = a; write_data = d;
    #1;
    e = error;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    bus_rd(a, d, e);
    chk(tag, d, exp);
  endtask

  task automatic strobe(input logic [31:0] d);
    @(negedge clk);
    src_valid = 4'b0110;
    src_data  = {32'hbad3, d, 32'hbad1, 32'hbad0};
    @(posedge clk);
    #1;
    src_valid = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    reset_n = 1'b0; cs = 1'b0; we = 1'b0; address = '0;
    write_data = '0; src_data = '0; src_valid = '0; csprng_error = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    chk("rst_secerr", 32'(security_error), 32'd0);
    chk("rst_reseed", 32'(csprng_reseed), 32'd0);
    rd_chk("name0", 8'h00, 32'h74726e67);
    rd_chk("name1", 8'h01, 32'h2d646267);
    rd_chk("version", 8'h02, 32'h302e3130);
    rd_chk("rounds_rst", 8'h0a, 32'd24);
    rd_chk("srcen_rst", 8'h0b, 32'hf);
    rd_chk("status_rst", 8'h09, ST_IDLE);
    rd_chk("ctrl_rst", 8'h08, 32'h0);

    bus_wr(8'h08, 32'h2, e);
    chk("reseed_hi", 32'(csprng_reseed), 32'd1);
    @(posedge clk); #1;
    chk("reseed_lo", 32'(csprng_reseed), 32'd0);
    rd_chk("ctrl_after_reseed", 8'h08, 32'h0);

    bus_wr(8'h00, 32'h5, e);
    chk("wr_ro_err", 32'(e), 32'd1);
    bus_rd(8'h3f, d, e);
    chk("rd_unmap_err", 32'(e), 32'd1);
    chk("rd_unmap_data", d, 32'h0);
    rd_chk("name0_kept", 8'h00, 32'h74726e67);
    bus_wr(8'h0c, 32'h5, e);
    chk("sel_bad_err", 32'(e), 32'd1);
    rd_chk("sel_kept", 8'h0c, 32'h0);
    bus_wr(8'h0a, 32'h13, e);
    chk("rounds_wr_err", 32'(e), 32'd0);
    chk("rounds_port", 32'(csprng_num_rounds), 32'h13);

    @(negedge clk);
    csprng_error = 1'b1;
    @(posedge clk); #1;
    csprng_error = 1'b0;
    rd_chk("err_set", 8'h09, ST_IDLE | 32'h1);
    @(negedge clk);
    csprng_error = 1'b1;
    cs = 1'b1; we = 1'b1; address = 8'h09; write_data = 32'h1;
    @(posedge clk); #1;
    csprng_error = 1'b0; cs = 1'b0; we = 1'b0;
    rd_chk("err_set_wins", 8'h09, ST_IDLE | 32'h1);
    chk("secerr_on", 32'(security_error), 32'd1);
    bus_wr(8'h09, 32'h1, e);
    rd_chk("err_w1c", 8'h09, ST_IDLE);
    chk("secerr_off", 32'(security_error), 32'd0);

    bus_wr(8'h08, 32'h1, e);
    bus_wr(8'h0c, 32'h2, e);
    chk("debug_mode", 32'(csprng_debug_mode), 32'd1);
`ifdef TRNG_DEBUG_FIFO_EN
    for (int i = 0; i < 20; i++) strobe(32'h1000 + 32'(i));
    rd_chk("level_full", 8'h0d, 32'd16);
    rd_chk("status_full", 8'h09, 32'hc);
    chk("secerr_ovf", 32'(security_error), 32'd1);
    for (int i = 0; i < 16; i++) begin
      bus_rd(8'h10, d, e);
      chk($sformatf("pop%0d", i), d, 32'h1000 + 32'(i));
    end
    rd_chk("level_drained", 8'h0d, 32'd0);
    rd_chk("status_drained", 8'h09, 32'ha);
    bus_rd(8'h10, d, e);
    chk("empty_pop_data", d, 32'h0);
    chk("empty_pop_err", 32'(e), 32'd0);
    bus_wr(8'h09, 32'h8, e);
    rd_chk("ovf_w1c", 8'h09, 32'h2);

    for (int i = 0; i < 3; i++) strobe(32'h2000 + 32'(i));
    @(negedge clk);
    cs = 1'b1; we = 1'b0; address = 8'h10;
    src_valid = 4'b0100;
    src_data  = {32'h0, 32'h2003, 64'h0};
    #1;
    d = read_data;
    @(posedge clk); #1;
    cs = 1'b0; src_valid = '0;
    chk("pushpop_head", d, 32'h2000);
    rd_chk("pushpop_level", 8'h0d, 32'd3);
    for (int i = 1; i < 4; i++) begin
      bus_rd(8'h10, d, e);
      chk($sformatf("pp_pop%0d", i), d, 32'h2000 + 32'(i));
    end

    strobe(32'h3000);
    strobe(32'h3001);
    rd_chk("pre_flush", 8'h0d, 32'd2);
    bus_wr(8'h08, 32'h0, e);
    rd_chk("flushed", 8'h0d, 32'd0);
    bus_wr(8'h08, 32'h1, e);
    strobe(32'h4000);
`else
    strobe(32'h1000);
    bus_rd(8'h10, d, e);
    chk("data_unmapped", 32'(e), 32'd1);
    bus_rd(8'h0d, d, e);
    chk("level_unmapped", 32'(e), 32'd1);
    rd_chk("status_nofifo", 8'h09, 32'h0);
`endif

    @(negedge clk);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    chk("mid_rst_mode", 32'(csprng_debug_mode), 32'd0);
    rd_chk("mid_rst_rounds", 8'h0a, 32'd24);
    rd_chk("mid_rst_sel", 8'h0c, 32'h0);
    rd_chk("mid_rst_status", 8'h09, ST_IDLE);
`ifdef TRNG_DEBUG_FIFO_EN
    rd_chk("mid_rst_level", 8'h0d, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
